wb_result_drain: RTL
====================

Name: wb_result_drain

Overview:
- Writeback-side consumer of the execute stage's four-result bundle (resN_wb/resN/resN_is_reg/resN_dest/resN_size, plus the EIP/segment-load tags and EIP).
- Captures one bundle and retires its slots in order: register results go to the register-file write port, EIP/segment results go to the redirect port, and memory results go through a req/ack handshake to the memory write path.
- Raises busy to stall the upstream while draining.

Parameters:
- DATA_W, 64, result data width.
- ADDR_W, 32, destination (register id or memory address) width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  bundle valid from execute.
- resK_wb  in  1  slot K (K=1..4) write-enable.
- resK  in  DATA_W  slot K data.
- resK_is_reg  in  1  slot K targets a register (1) or memory (0).
- resK_dest  in  ADDR_W  slot K register id or memory address.
- resK_size  in  2  slot K size: 00=8b, 01=16b, 10=32b, 11=64b.
- load_eip_in_res1, load_segReg_in_res1, load_eip_in_res2, load_segReg_in_res2  in  1 each  redirect tags for slots 1/2.
- eip_in  in  32  EIP accompanying the bundle.
- busy  out  1  drain in progress; upstream holds while high.
- reg_we  out  1  register write strobe.
- reg_id  out  ADDR_W  register write id.
- reg_data  out  DATA_W  register write data.
- reg_size  out  2  register write size.
- mem_req  out  1  memory write request.
- mem_addr  out  ADDR_W  memory write address.
- mem_data  out  DATA_W  memory write data.
- mem_size  out  2  memory write size.
- mem_ack  in  1  memory write accepted.
- eip_ld  out  1  EIP load strobe.
- seg_ld  out  1  CS load strobe.
- redir_data  out  DATA_W  EIP/CS load value (slot data).
- eip_out  out  32  captured EIP.
- overrun  out  1  sticky: valid_in arrived while busy.

Behaviour:
- Reset value of every output is 0. Reset mid-drain discards all slots, returns to IDLE, clears overrun, and drops mem_req immediately (asynchronously).
- States: IDLE and DRAIN. Registers hold a 4-entry slot buffer, a pending mask, and a 2-bit current index.
- Capture: at a clk edge in IDLE with valid_in=1 and any resK_wb=1:
  - latch all slots, the tags and eip_in;
  - pending mask = {res4_wb..res1_wb};
  - go to DRAIN; busy=1 from the next cycle.
- If valid_in=1 and all wb=0, nothing is captured and the block stays IDLE.
- busy = (state==DRAIN). It is registered; the upstream may present a new bundle in the first IDLE cycle.
- DRAIN retires slots in order 1 to 4, skipping slots whose pending bit is 0. At most one slot retires per cycle.
- Current slot is a redirect (slot 1/2 with a load_eip or load_segReg tag):
  - eip_ld and/or seg_ld = 1 for one cycle, redir_data = slot data;
  - no reg_we; retires that cycle.
- Current slot is a register (is_reg=1, untagged):
  - reg_we=1, with reg_id/data/size from the slot; retires that cycle.
- Current slot is memory (is_reg=0):
  - mem_req=1 with addr/data/size held stable until the cycle mem_ack=1; retires that cycle.
  - mem_req never deasserts before ack.
  - mem_ack while mem_req=0 is ignored.
- Outputs are combinational from the registered current slot and state; the retire updates the pending mask at the clock edge.
- When the last pending bit clears, the FSM returns to IDLE the next cycle.
- Latency per bundle: one capture edge plus one cycle per reg/redirect slot, plus (1 + wait) cycles per memory slot.
- eip_out is updated at capture and holds until the next capture.
- valid_in=1 while busy: the bundle is not captured and overrun is set (sticky until reset).

Optional Feature:
- Macro WB_DUAL_REG_EN.
- Defined: adds ports reg2_we (out, 1), reg2_id (out, ADDR_W), reg2_data (out, DATA_W) and reg2_size (out, 2).
  - When the current slot and the next pending slot are both untagged register slots with different reg_id, both retire in the same cycle (the second on reg2_*).
  - With equal ids they retire singly, in order.
- Undefined: the reg2 ports are absent; one slot retires per cycle.

Test Plan:
- Bundle with res1 reg (id 3, data 0x1234, size 10) and res2 reg (id 5, 0xABCD); others wb=0 → reg_we in cycles 1 and 2 with ids 3 then 5, busy high for 2 cycles, then IDLE.
- res1 memory (addr 0x1000, data 0xDEAD, size 10), mem_ack held low for 3 cycles → mem_req high 4 cycles with addr/data stable, retires on ack; busy drops the next cycle.
- res1 tagged load_eip (data 0x0000_4000), res2 tagged load_segReg (0x0008) → eip_ld in cycle 1, seg_ld in cycle 2, reg_we never asserted.
- valid_in=1 during DRAIN → bundle ignored, overrun=1 and stays 1; rst clears it.
- rst asserted while mem_req=1 awaiting ack → all outputs 0 immediately, IDLE, next bundle is captured normally.
- WB_DUAL_REG_EN with res1 reg id 2 and res2 reg id 7 → reg_we and reg2_we in the same cycle; with ids 2 and 2 → two separate cycles, with id 2 ending at res2's data.

Source files
------------

// File: rtl/wb_result_drain_if.sv
// Writeback result bundle bus: execute-side bundle in, register/memory/redirect write ports out.
// Latency: n/a (wires only); backpressure: busy from the drain stalls the execute side.
`timescale 1ns/1ps
interface wb_result_drain_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              valid_in;
    logic              res1_wb, res2_wb, res3_wb, res4_wb;
    logic [DATA_W-1:0] res1, res2, res3, res4;
    logic              res1_is_reg, res2_is_reg, res3_is_reg, res4_is_reg;
    logic [ADDR_W-1:0] res1_dest, res2_dest, res3_dest, res4_dest;
    logic [1:0]        res1_size, res2_size, res3_size, res4_size;
    logic              load_eip_in_res1, load_segReg_in_res1;
    logic              load_eip_in_res2, load_segReg_in_res2;
    logic [31:0]       eip_in;
    logic              busy;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_id;
    logic [DATA_W-1:0] reg_data;
    logic [1:0]        reg_size;
`ifdef WB_DUAL_REG_EN
    logic              reg2_we;
    logic [ADDR_W-1:0] reg2_id;
    logic [DATA_W-1:0] reg2_data;
    logic [1:0]        reg2_size;
`endif
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        mem_size;
    logic              mem_ack;
    logic              eip_ld, seg_ld;
    logic [DATA_W-1:0] redir_data;
    logic [31:0]       eip_out;
    logic              overrun;

    modport slave (
        input  valid_in, res1_wb, res2_wb, res3_wb, res4_wb, res1, res2, res3, res4,
               res1_is_reg, res2_is_reg, res3_is_reg, res4_is_reg,
               res1_dest, res2_dest, res3_dest, res4_dest,
               res1_size, res2_size, res3_size, res4_size,
               load_eip_in_res1, load_segReg_in_res1, load_eip_in_res2, load_segReg_in_res2,
               eip_in, mem_ack,
        output busy, reg_we, reg_id, reg_data, reg_size,
`ifdef WB_DUAL_REG_EN
               reg2_we, reg2_id, reg2_data, reg2_size,
`endif
               mem_req, mem_addr, mem_data, mem_size,
               eip_ld, seg_ld, redir_data, eip_out, overrun
    );

    modport master (
        output valid_in, res1_wb, res2_wb, res3_wb, res4_wb, res1, res2, res3, res4,
               res1_is_reg, res2_is_reg, res3_is_reg, res4_is_reg,
               res1_dest, res2_dest, res3_dest, res4_dest,
               res1_size, res2_size, res3_size, res4_size,
               load_eip_in_res1, load_segReg_in_res1, load_eip_in_res2, load_segReg_in_res2,
               eip_in, mem_ack,
        input  busy, reg_we, reg_id, reg_data, reg_size,
`ifdef WB_DUAL_REG_EN
               reg2_we, reg2_id, reg2_data, reg2_size,
`endif
               mem_req, mem_addr, mem_data, mem_size,
               eip_ld, seg_ld, redir_data, eip_out, overrun
    );
endinterface

// File: rtl/wb_result_drain.sv
// Captures a 4-slot result bundle and retires slots in order to reg/redirect/memory ports (WB_DUAL_REG_EN: paired reg writes).
// Latency: capture edge + 1 cycle per reg/redirect slot + (1 + ack wait) per memory slot.
// Backpressure: busy holds upstream while draining; memory slots wait on mem_ack.
`timescale 1ns/1ps
module wb_result_drain #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_result_drain_if.slave  bus
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] s_data [4];
    logic [ADDR_W-1:0] s_dest [4];
    logic [1:0]        s_size [4];
    logic [3:0]        s_is_reg;
    logic [3:0]        pend;
    logic [1:0]        cur;
    logic [1:0]        eip_tag, seg_tag;
    logic [31:0]       eip_r;
    logic              overrun_r;

    logic [3:0]        in_wb, in_is_reg;
    logic [DATA_W-1:0] in_data [4];
    logic [ADDR_W-1:0] in_dest [4];
    logic [1:0]        in_size [4];

    logic              draining, cur_redir, do_redir, do_reg, do_mem;
    logic [3:0]        retire_mask, pend_nxt;
`ifdef WB_DUAL_REG_EN
    logic [3:0]        rest;
    logic [1:0]        nxt;
    logic              do_dual;
`endif

    function automatic logic [1:0] first_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        in_wb      = {bus.res4_wb, bus.res3_wb, bus.res2_wb, bus.res1_wb};
        in_is_reg  = {bus.res4_is_reg, bus.res3_is_reg, bus.res2_is_reg, bus.res1_is_reg};
        in_data[0] = bus.res1;      in_data[1] = bus.res2;
        in_data[2] = bus.res3;      in_data[3] = bus.res4;
        in_dest[0] = bus.res1_dest; in_dest[1] = bus.res2_dest;
        in_dest[2] = bus.res3_dest; in_dest[3] = bus.res4_dest;
        in_size[0] = bus.res1_size; in_size[1] = bus.res2_size;
        in_size[2] = bus.res3_size; in_size[3] = bus.res4_size;
    end

    // Only slots 1/2 carry redirect tags; a tag outranks is_reg.
    always_comb begin
        draining  = (state == DRAIN);
        cur_redir = !cur[1] && (eip_tag[cur[0]] || seg_tag[cur[0]]);
        do_redir  = draining && cur_redir;
        do_reg    = draining && !cur_redir && s_is_reg[cur];
        do_mem    = draining && !cur_redir && !s_is_reg[cur];
        retire_mask = 4'b0000;
        if (do_redir || do_reg || (do_mem && bus.mem_ack))
            retire_mask[cur] = 1'b1;
`ifdef WB_DUAL_REG_EN
        rest    = pend & ~(4'b0001 << cur);
        nxt     = first_idx(rest);
        do_dual = do_reg && (rest != 4'b0000) && s_is_reg[nxt]
                  && (nxt[1] || !(eip_tag[nxt[0]] || seg_tag[nxt[0]]))
                  && (s_dest[nxt] != s_dest[cur]);
        if (do_dual)
            retire_mask[nxt] = 1'b1;
`endif
        pend_nxt = pend & ~retire_mask;
    end

    always_comb begin
        bus.busy       = draining;
        bus.eip_out    = eip_r;
        bus.overrun    = overrun_r;
        bus.reg_we     = do_reg;
        bus.reg_id     = do_reg ? s_dest[cur] : '0;
        bus.reg_data   = do_reg ? s_data[cur] : '0;
        bus.reg_size   = do_reg ? s_size[cur] : '0;
        bus.mem_req    = do_mem;
        bus.mem_addr   = do_mem ? s_dest[cur] : '0;
        bus.mem_data   = do_mem ? s_data[cur] : '0;
        bus.mem_size   = do_mem ? s_size[cur] : '0;
        bus.eip_ld     = do_redir && eip_tag[cur[0]];
        bus.seg_ld     = do_redir && seg_tag[cur[0]];
        bus.redir_data = do_redir ? s_data[cur] : '0;
`ifdef WB_DUAL_REG_EN
        bus.reg2_we    = do_dual;
        bus.reg2_id    = do_dual ? s_dest[nxt] : '0;
        bus.reg2_data  = do_dual ? s_data[nxt] : '0;
        bus.reg2_size  = do_dual ? s_size[nxt] : '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 4'b0000;
            cur       <= 2'd0;
            s_is_reg  <= 4'b0000;
            eip_tag   <= 2'b00;
            seg_tag   <= 2'b00;
            eip_r     <= 32'd0;
            overrun_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_data[i] <= '0;
                s_dest[i] <= '0;
                s_size[i] <= '0;
            end
        end else begin
            if (bus.valid_in && draining)
                overrun_r <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.valid_in && (in_wb != 4'b0000)) begin
                        for (int i = 0; i < 4; i++) begin
                            s_data[i] <= in_data[i];
                            s_dest[i] <= in_dest[i];
                            s_size[i] <= in_size[i];
                        end
                        s_is_reg <= in_is_reg;
                        eip_tag  <= {bus.load_eip_in_res2, bus.load_eip_in_res1};
                        seg_tag  <= {bus.load_segReg_in_res2, bus.load_segReg_in_res1};
                        eip_r    <= bus.eip_in;
                        pend     <= in_wb;
                        cur      <= first_idx(in_wb);
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retire_mask != 4'b0000) begin
                        pend <= pend_nxt;
                        cur  <= first_idx(pend_nxt);
                        if (pend_nxt == 4'b0000)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
